// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then clock
// out one byte with odd parity on the device's clock, ending with an ACK check.
module ps2_host_tx #(
   parameter int CLKFREQ = 28000,
   parameter int FILTER  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       send,
   input  logic       ps2clk_i,
   input  logic       ps2dat_i,
   output logic       ps2clk_low,
   output logic       ps2dat_low,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int FW = $clog2(FILTER + 1);
   localparam logic [18:0] T_INH_M   = 19'(CLKFREQ / 10 - 1);
   localparam logic [18:0] T_ST_M    = 19'(CLKFREQ / 200 - 1);
   localparam logic [18:0] T_FIRST_M = 19'(CLKFREQ * 15 - 1);
   localparam logic [18:0] T_BIT_M   = 19'(CLKFREQ - 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, START, WAITDEV, BITS, WAITIDLE, ERR
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  clk_s_q, clk_s_d;
   logic [1:0]  dat_s_q, dat_s_d;
   logic        filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic        fall_q, fall_d;
   logic [18:0] tmr_q, tmr_d;
   logic [3:0]  edge_q, edge_d;
   logic [8:0]  word_q, word_d;
   logic        clk_low_q, clk_low_d;
   logic        dat_low_q, dat_low_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        to_err;
   logic [3:0]  nxt_edge;

   always_comb begin
      clk_s_d   = {clk_s_q[0], ps2clk_i};
      dat_s_d   = {dat_s_q[0], ps2dat_i};
      filt_d    = filt_q;
      fcnt_d    = '0;
      state_d   = state_q;
      tmr_d     = tmr_q;
      edge_d    = edge_q;
      word_d    = word_q;
      clk_low_d = clk_low_q;
      dat_low_d = dat_low_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      to_err    = 1'b0;
      nxt_edge  = edge_q + 4'd1;

      // a new clock level needs FILTER consecutive agreeing samples
      if (clk_s_q[1] != filt_q) begin
         if (fcnt_q == FW'(FILTER - 1)) begin
            filt_d = clk_s_q[1];
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
      fall_d = filt_q & ~filt_d;

      case (state_q)
         IDLE: begin
            if (send && !done_q && !error_q) begin
               word_d    = {~^data, data};
               busy_d    = 1'b1;
               clk_low_d = 1'b1;
               tmr_d     = '0;
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (tmr_q == T_INH_M) begin
               dat_low_d = 1'b1;
               tmr_d     = '0;
               state_d   = START;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         START: begin
            if (tmr_q == T_ST_M) begin
               clk_low_d = 1'b0;
               edge_d    = '0;
               tmr_d     = '0;
               state_d   = WAITDEV;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         WAITDEV: begin
            if (fall_q) begin
               dat_low_d = ~word_q[0];
               edge_d    = 4'd1;
               tmr_d     = '0;
               state_d   = BITS;
            end else if (tmr_q == T_FIRST_M) begin
               to_err = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         BITS: begin
            if (fall_q) begin
               edge_d = nxt_edge;
               tmr_d  = '0;
               if (nxt_edge <= 4'd9) begin
                  dat_low_d = ~word_q[edge_q];
               end else if (nxt_edge == 4'd10) begin
                  dat_low_d = 1'b0;
               end else if (dat_s_q[1]) begin
                  to_err = 1'b1;
               end else begin
                  state_d = WAITIDLE;
               end
            end else if (tmr_q == T_BIT_M) begin
               to_err = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         WAITIDLE: begin
            if (filt_q && dat_s_q[1]) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (tmr_q == T_BIT_M) begin
               to_err = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (to_err) begin
         clk_low_d = 1'b0;
         dat_low_d = 1'b0;
         busy_d    = 1'b0;
         error_d   = 1'b1;
         state_d   = ERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         clk_s_q   <= 2'b11;
         dat_s_q   <= 2'b11;
         filt_q    <= 1'b1;
         fcnt_q    <= '0;
         fall_q    <= 1'b0;
         tmr_q     <= '0;
         edge_q    <= '0;
         word_q    <= '0;
         clk_low_q <= 1'b0;
         dat_low_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_s_q   <= clk_s_d;
         dat_s_q   <= dat_s_d;
         filt_q    <= filt_d;
         fcnt_q    <= fcnt_d;
         fall_q    <= fall_d;
         tmr_q     <= tmr_d;
         edge_q    <= edge_d;
         word_q    <= word_d;
         clk_low_q <= clk_low_d;
         dat_low_q <= dat_low_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign ps2clk_low = clk_low_q;
   assign ps2dat_low = dat_low_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks bytes out of the
// host and the captured frames are compared with a parity/frame model.
module tb_ps2_host_tx;

   localparam int CLKFREQ = 1000;
   localparam int FILTER  = 8;
   localparam int T_INH   = CLKFREQ / 10;
   localparam int T_ST    = CLKFREQ / 200;
   localparam int T_FIRST = CLKFREQ * 15;
   localparam int T_BIT   = CLKFREQ;
   localparam int HALF    = 30;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data = '0;
   logic       send = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2clk_low, ps2dat_low, busy, done, error;
   logic       clk_line, dat_line;
   logic [9:0] got;

   int checks = 0, failures = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_bad = 0;
   int cyc = 0, err_cyc = 0;

   assign clk_line = dev_clk & ~ps2clk_low;
   assign dat_line = dev_dat & ~ps2dat_low;

   always #5 clk = ~clk;

   ps2_host_tx #(.CLKFREQ(CLKFREQ), .FILTER(FILTER)) dut (
      .clk(clk), .rst_n(rst_n), .data(data), .send(send),
      .ps2clk_i(clk_line), .ps2dat_i(dat_line),
      .ps2clk_low(ps2clk_low), .ps2dat_low(ps2dat_low),
      .busy(busy), .done(done), .error(error)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (error) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
      if (done && error) both_cnt <= both_cnt + 1;
      if ((done || error) && busy) busy_bad <= busy_bad + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // frame as the device sees it: data LSB first, odd parity, stop=1
   function automatic logic [9:0] ref_word(input logic [7:0] b);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, (ones % 2 == 0), b};
   endfunction

   // mode: 0 ack, 1 nack, 2 silent, 3 stall, 4 glitch, 5 resend, 6 reset
   task automatic xfer(input logic [7:0] b, input int mode,
                       output logic [9:0] bits);
      int inh, st, t, d0, e0, f5, n, extra;
      logic [9:0] exp;
      bits = '0;
      d0 = done_cnt;
      e0 = err_cnt;
      f5 = 0;
      exp = ref_word(b);
      @(negedge clk);
      data = b;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      data = 8'($urandom);
      chk("busy_up", busy, 1);
      inh = 0;
      while (ps2clk_low && !ps2dat_low && inh < 20 * T_INH) begin
         inh++;
         @(negedge clk);
      end
      st = 0;
      while (ps2clk_low && ps2dat_low && st < 20 * T_INH) begin
         st++;
         @(negedge clk);
      end
      chk("inhibit_len", inh, T_INH);
      chk("start_len", st, T_ST);
      chk("start_bit", dat_line, 0);
      if (mode == 2) begin
         t = 0;
         while (!error && t < 2 * T_FIRST) begin
            t++;
            @(negedge clk);
         end
         chk("nores_win", int'(t >= T_FIRST - FILTER - 3 &&
                               t <= T_FIRST + FILTER + 3), 1);
         chk("nores_clk", ps2clk_low, 0);
         chk("nores_dat", ps2dat_low, 0);
      end else begin
         n = (mode == 3) ? 5 : 11;
         repeat (20) @(negedge clk);
         for (int k = 1; k <= n; k++) begin
            if (k == 11 && mode != 1) begin
               dev_dat = 1'b0;
               repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            if (k == 5) f5 = cyc;
            if (mode == 6 && k == 4) begin
               repeat (HALF) @(negedge clk);
               rst_n = 1'b0;
               #1;
               chk("rst_clk", ps2clk_low, 0);
               chk("rst_dat", ps2dat_low, 0);
               chk("rst_busy", busy, 0);
               repeat (2) @(negedge clk);
               dev_clk = 1'b1;
               repeat (5) @(negedge clk);
               rst_n = 1'b1;
               break;
            end
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k-1] = dat_line;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            if (mode == 4 && k == 3) begin
               dev_clk = 1'b0;
               repeat (3) @(negedge clk);
               dev_clk = 1'b1;
               repeat (HALF) @(negedge clk);
            end
            if (mode == 5 && k == 6) begin
               data = ~b;
               send = 1'b1;
               @(negedge clk);
               send = 1'b0;
            end
         end
         dev_dat = 1'b1;
         if (mode != 6) begin
            t = 0;
            while (done_cnt == d0 && err_cnt == e0 && t < 2 * T_BIT) begin
               t++;
               @(negedge clk);
            end
         end
         if (mode == 3)
            chk("stall_win", int'(err_cyc - f5 >= T_BIT &&
                                  err_cyc - f5 <= T_BIT + FILTER + 6), 1);
      end
      extra = 0;
      repeat (60) begin
         @(negedge clk);
         if (ps2clk_low || ps2dat_low || busy) extra++;
      end
      chk("idle_after", extra, 0);
      if (mode == 0 || mode == 4 || mode == 5) begin
         chk("done_cnt", done_cnt - d0, 1);
         chk("err_cnt", err_cnt - e0, 0);
         chk("frame", bits, exp);
      end else if (mode == 6) begin
         chk("rst_done", done_cnt - d0, 0);
         chk("rst_err", err_cnt - e0, 0);
      end else begin
         chk("fail_done", done_cnt - d0, 0);
         chk("fail_err", err_cnt - e0, 1);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ps2clk_low", ps2clk_low, 0);
      chk("rst_ps2dat_low", ps2dat_low, 0);
      chk("rst_busy0", busy, 0);
      chk("rst_done0", done, 0);
      chk("rst_error0", error, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      xfer(8'hED, 0, got);
      chk("ed_bits", got, 10'h3ED);
      xfer(8'h00, 0, got);
      chk("par_00", got[8], 1);
      xfer(8'h01, 0, got);
      chk("par_01", got[8], 0);
      xfer(8'hFF, 0, got);
      chk("par_ff", got[8], 1);
      for (int i = 0; i < 5; i++) xfer(8'($urandom), 0, got);

      xfer(8'hF4, 2, got);
      xfer(8'($urandom), 1, got);
      xfer(8'($urandom), 3, got);
      xfer(8'($urandom), 4, got);
      xfer(8'($urandom), 5, got);
      xfer(8'h00, 6, got);
      xfer(8'($urandom), 0, got);

      chk("excl", both_cnt, 0);
      chk("busy_at_pulse", busy_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
